seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 178 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serial pattern detector with session control.
//
// A session starts from IDLE on `start`. The configuration (pattern, effective
// length, overlap mode, detection limit and window limit) is latched in that
// same cycle. In RUN, one bit of `inp` is accepted every cycle. `det` is a Mealy
// output: it goes high in the cycle whose `inp` completes a match.
// A session ends in one of three ways:
//   - the detection limit is reached: DONE, timeout=0
//   - the window expires:             DONE, timeout=1
//   - abort:                          back to IDLE with no done pulse
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active low
//   inp      serial data bit, one per cycle
//   start    session start request (IDLE only)
//   abort    session cancel request (RUN only)
//   cfg_pat  pattern; cfg_pat[len-1] is received first
//   cfg_len  pattern length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_ovl  1 = overlapping detection
//   cfg_max  detections that end the session (0 = unlimited)
//   cfg_win  RUN cycles that end the session (0 = unlimited)
//   det      match in the current RUN cycle
//   busy     state is RUN
//   done     one-cycle pulse on a normal session end
//   timeout  last session ended by window expiry
//   det_cnt  detections in the current or last session
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [2:0]       cfg_len,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic [CNT_W-1:0] cfg_win,
  output logic             det,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] det_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // cfg_len is only 3 bits wide, so the usable length is capped at 7 regardless of PAT_W.
  localparam logic [2:0] LEN_MAX = (PAT_W > 7) ? 3'd7 : 3'(PAT_W);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [2:0]       r_len;
  logic             r_ovl;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_win;
  // Only the last len-1 bits are ever compared against history, so PAT_W-1 bits suffice.
  logic [PAT_W-2:0] r_hist;
  logic [2:0]       r_bcnt;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  logic [2:0]       w_len_eff;
  logic [PAT_W-1:0] w_win;
  logic [PAT_W-1:0] w_mask;
  logic             w_match;
  logic             w_det;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cyc_inc;
  logic             w_max_hit;
  logic             w_win_hit;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [2:0] sat_inc_bits(input logic [2:0] v);
    return (&v) ? v : v + 3'd1;
  endfunction

  always_comb begin
    w_len_eff = cfg_len;
    if (cfg_len == 3'd0)
      w_len_eff = 3'd1;
    else if (cfg_len > LEN_MAX)
      w_len_eff = LEN_MAX;
  end

  // Compare the newest len bits (history followed by the current inp) against the pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_win     = {r_hist, inp};
  assign w_match   = (r_bcnt >= (r_len - 3'd1)) && ((w_win & w_mask) == (r_pat & w_mask));
  assign w_det     = (r_state == S_RUN) && !abort && w_match;
  assign w_cnt_inc = sat_inc_cnt(r_cnt);
  assign w_cyc_inc = sat_inc_cnt(r_cyc);
  assign w_max_hit = w_det && (r_max != '0) && (w_cnt_inc == r_max);
  assign w_win_hit = (r_win != '0) && (w_cyc_inc == r_win);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= 3'd0;
      r_ovl     <= 1'b0;
      r_max     <= '0;
      r_win     <= '0;
      r_hist    <= '0;
      r_bcnt    <= 3'd0;
      r_cyc     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pat     <= cfg_pat;
            r_len     <= w_len_eff;
            r_ovl     <= cfg_ovl;
            r_max     <= cfg_max;
            r_win     <= cfg_win;
            r_hist    <= '0;
            r_bcnt    <= 3'd0;
            r_cyc     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort beats every end condition and freezes the count from earlier cycles.
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_hist <= w_win[PAT_W-2:0];
            r_cyc  <= w_cyc_inc;
            if (w_det) begin
              r_cnt <= w_cnt_inc;
              // Without overlap, restart the bit count so no bit serves two matches.
              r_bcnt <= r_ovl ? sat_inc_bits(r_bcnt) : 3'd0;
            end else begin
              r_bcnt <= sat_inc_bits(r_bcnt);
            end
            // Reaching the detection limit wins over a window expiry in the same cycle.
            if (w_max_hit) begin
              r_state   <= S_DONE;
              r_timeout <= 1'b0;
            end else if (w_win_hit) begin
              r_state   <= S_DONE;
              r_timeout <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign det     = w_det;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign timeout = r_timeout;
  assign det_cnt = r_cnt;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       inp;
  logic       start;
  logic       abort;
  logic [3:0] cfg_pat;
  logic [2:0] cfg_len;
  logic       cfg_ovl;
  logic [7:0] cfg_max;
  logic [7:0] cfg_win;
  logic       det;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] det_cnt;

  seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .inp(inp), .start(start), .abort(abort),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cfg_max(cfg_max), .cfg_win(cfg_win),
    .det(det), .busy(busy), .done(done), .timeout(timeout), .det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    bit       to;
    bit [7:0] cnt;
  } end_t;

  bit   exp_det_q[$];
  end_t exp_end_q[$];
  bit   stim[1:64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each RUN cycle consumes one expected det value; each done pulse
  // consumes one expected session result.
  bit   mon_e;
  end_t mon_r;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        check("run_cycle_expected", 32'(exp_det_q.size() > 0), 1);
        if (exp_det_q.size() > 0) begin
          mon_e = exp_det_q.pop_front();
          check("det", 32'(det), 32'(mon_e));
        end
      end
      if (done === 1'b1) begin
        check("done_expected", 32'(exp_end_q.size() > 0), 1);
        if (exp_end_q.size() > 0) begin
          mon_r = exp_end_q.pop_front();
          check("done_timeout", 32'(timeout), 32'(mon_r.to));
          check("done_det_cnt", 32'(det_cnt), 32'(mon_r.cnt));
        end
      end
    end
  end

  task automatic load_stim(input logic [63:0] v, input int n);
    for (int k = 1; k <= n; k++) stim[k] = v[n-k];
  endtask

  // Reference model plus driver for one session. Stream bits are stim[1..n];
  // if nothing ends the session by then, cycle n+1 aborts it.
  task automatic session(input logic [3:0] pat, input logic [2:0] len, input bit ovl,
                         input logic [7:0] mx, input logic [7:0] win,
                         input int n, input int abort_at);
    int L, last, cnt, endk;
    bit to, normal, hit;
    L = (len == 0) ? 1 : ((len > 4) ? 4 : int'(len));
    last = 0; cnt = 0; endk = 0; normal = 0; to = 0;
    for (int k = 1; k <= n + 1 && endk == 0; k++) begin
      if (k == abort_at || k == n + 1) begin
        exp_det_q.push_back(1'b0);
        endk = k;
      end else begin
        // A match needs L fresh bits since the last non-overlapping match.
        hit = (k - last >= L);
        if (hit)
          for (int j = 0; j < L; j++)
            if (stim[k-L+1+j] != pat[L-1-j]) hit = 0;
        exp_det_q.push_back(hit);
        if (hit) begin
          if (cnt < 255) cnt++;
          if (!ovl) last = k;
        end
        if (hit && mx != 0 && cnt == int'(mx)) begin
          endk = k; normal = 1; to = 0;
        end else if (win != 0 && k == int'(win)) begin
          endk = k; normal = 1; to = 1;
        end
      end
    end
    if (normal) exp_end_q.push_back('{to, 8'(cnt)});

    cfg_pat = pat; cfg_len = len; cfg_ovl = ovl; cfg_max = mx; cfg_win = win;
    start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= endk; k++) begin
      inp   = (k <= n) ? stim[k] : 1'b0;
      abort = (k == endk) && !normal;
      // Start and configuration must be ignored while running.
      start   = 1'($urandom);
      cfg_pat = 4'($urandom); cfg_len = 3'($urandom); cfg_ovl = 1'($urandom);
      cfg_max = 8'($urandom); cfg_win = 8'($urandom);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    if (normal) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    inp = 1'b1;
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_det", 32'(det), 0);
    check("hold_det_cnt", 32'(det_cnt), 32'(cnt));
    check("hold_timeout", 32'(timeout), 32'(normal && to));
    check("scoreboard_drained", 32'(exp_det_q.size() + exp_end_q.size()), 0);
    @(posedge clk); #1;
    check("hold_det_cnt_2", 32'(det_cnt), 32'(cnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; inp = 1'b1; start = 1'b1; abort = 1'b0;
    cfg_pat = 4'hF; cfg_len = 3'd1; cfg_ovl = 1'b0; cfg_max = 8'd0; cfg_win = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_det", 32'(det), 0);
    check("rst_det_cnt", 32'(det_cnt), 0);
    check("rst_timeout", 32'(timeout), 0);
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Case 1 / 2: 000 pattern, non-overlapping then overlapping, window 8
    load_stim(64'b00000010, 8);
    session(4'b0000, 3'd3, 1'b0, 8'd0, 8'd8, 8, 0);
    check("case1_cnt", 32'(det_cnt), 2);
    check("case1_timeout", 32'(timeout), 1);
    session(4'b0000, 3'd3, 1'b1, 8'd0, 8'd8, 8, 0);
    check("case2_cnt", 32'(det_cnt), 4);

    // Case 3: 1011 overlapping, stop after two detections
    load_stim(64'b1011011, 7);
    session(4'b1011, 3'd4, 1'b1, 8'd2, 8'd0, 7, 0);
    check("case3_cnt", 32'(det_cnt), 2);
    check("case3_timeout", 32'(timeout), 0);

    // Case 4: detection limit and window expire together; the limit wins
    load_stim(64'b101, 3);
    session(4'b0101, 3'd3, 1'b0, 8'd1, 8'd3, 3, 0);
    check("case4_cnt", 32'(det_cnt), 1);
    check("case4_timeout", 32'(timeout), 0);

    // Case 5: abort in RUN cycle 5 while a match is present
    load_stim(64'b111111, 6);
    session(4'b0001, 3'd1, 1'b0, 8'd0, 8'd0, 6, 5);
    check("case5_cnt", 32'(det_cnt), 4);

    // Reset in mid-RUN discards the session
    mon_en = 1'b0;
    cfg_pat = 4'b0001; cfg_len = 3'd1; cfg_ovl = 1'b1; cfg_max = 8'd0; cfg_win = 8'd0;
    start = 1'b1; inp = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy", 32'(busy), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_det", 32'(det), 0);
    check("midrst_det_cnt", 32'(det_cnt), 0);
    check("midrst_timeout", 32'(timeout), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Case 6: length 0 acts as 1, length 7 acts as 4
    for (int k = 1; k <= 20; k++) stim[k] = 1'($urandom);
    session(4'b0001, 3'd0, 1'b0, 8'd0, 8'd0, 20, 0);
    for (int k = 1; k <= 30; k++) stim[k] = 1'($urandom);
    session(4'b1011, 3'd7, 1'b1, 8'd0, 8'd0, 30, 0);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int n, ab;
      n  = $urandom_range(4, 40);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      for (int k = 1; k <= n; k++) stim[k] = 1'($urandom);
      session(4'($urandom), 3'($urandom), 1'($urandom), 8'($urandom_range(0, 4)),
              8'($urandom_range(0, 30)), n, ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
